psg_write_bridge: RTL
=====================

PSG_WRITE_BRIDGE -- requirements
Module: psg_write_bridge

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-002 Parameter GAP, default 2, idle CLK cycles after each strobe before the next SETUP; 2..15.
REQ-003 Port CLK, input, 1, single clock for all logic.
REQ-004 Port RST, input, 1, reset; asynchronous assertion, active-high.
REQ-005 Port cpu_wr, input, 1, one-cycle write request from the CPU-side decoder.
REQ-006 Port cpu_data, input, 8, PSG command byte, valid when cpu_wr=1.
REQ-007 Port cpu_busy, output, 1, high when the FIFO is full.
REQ-008 Port level, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-009 Port nWE, output, 1, PSG write enable, active-low.
REQ-010 Port nCE, output, 1, PSG chip enable, active-low.
REQ-011 Port D, output, 8, PSG data bus.
REQ-012 Port READY, input, 1, PSG ready; high permits a new transfer.

Function
REQ-013 Accept a write on a CLK edge when cpu_wr=1 and full=0; store cpu_data at the write pointer.
REQ-014 Evaluate full before any same-edge pop: a write while full is dropped, even if a pop occurs on that edge.
REQ-015 Simultaneous accepted write and pop on one edge: level unchanged, both pointers advance.
REQ-016 Pointers wrap modulo DEPTH; full when level==DEPTH; empty when level==0.
REQ-017 FSM states: IDLE, SETUP, STROBE, GAP.
REQ-018 IDLE -> SETUP when FIFO is non-empty and READY=1 (READY sampled in IDLE only); otherwise stay in IDLE.
REQ-019 On the IDLE->SETUP edge, load D with the FIFO head byte; nWE=nCE=1 throughout SETUP.
REQ-020 SETUP -> STROBE unconditionally after 1 cycle.
REQ-021 In STROBE, nWE=nCE=0 for exactly one CLK cycle; on its exit edge, pop the FIFO and go to GAP.
REQ-022 GAP lasts exactly GAP cycles (down-counter) with nWE=nCE=1 and D held; then go to IDLE.
REQ-023 Latency: write accepted on edge E0 into an empty FIFO with READY=1 and FSM in IDLE -> nWE/nCE low between edges E2 and E3.
REQ-024 Throughput: at most one byte per 3+GAP cycles (5 cycles at default); back-to-back bytes keep FIFO order.
REQ-025 nWE, nCE and D are registered outputs with no combinational path from any input.
REQ-026 D stays stable from the start of SETUP through the end of GAP.

Reset
REQ-027 While RST=1: state=IDLE, pointers=0, level=0, cpu_busy=0, nWE=1, nCE=1, D=8'h00, gap counter=0.
REQ-028 RST asserted mid-STROBE forces nWE/nCE high immediately (asynchronously); the in-flight byte and all FIFO contents are discarded.
REQ-029 FIFO storage array need not be reset; no output depends on unreset storage while empty.

Configuration
REQ-030 Macro PSG_BRIDGE_DROP_CNT_EN defined: add output drop_count, 8 bits, reset 0, incremented on each write dropped per REQ-014, saturating at 8'hFF.
REQ-031 Macro PSG_BRIDGE_DROP_CNT_EN undefined: drop_count port and logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset, then single write 8'h9F with READY=1 -> D=8'h9F from E1; nWE/nCE low exactly one cycle at E2-E3; level returns to 0.
REQ-033 Three back-to-back writes 8'h80, 8'h3F, 8'hC5 -> three strobes in that order, 5 cycles apart (GAP=2), each one cycle wide.
REQ-034 Hold READY=0 and write 8'h90 -> no strobe, level=1; raise READY -> strobe follows 2 cycles later.
REQ-035 Nine writes with READY=0 (DEPTH=8) -> cpu_busy=1 after the 8th write, 9th byte dropped, drop_count=1 (macro on); release READY -> exactly 8 strobes.
REQ-036 Assert RST during STROBE -> nWE=nCE=1 in the same cycle, level=0, no further strobes after release.

Source files
------------

// File: rtl/psg_write_bridge.sv
// CPU-to-PSG write bridge: byte FIFO drained by a SETUP/STROBE/GAP sequencer.
// Optional PSG_BRIDGE_DROP_CNT_EN adds a saturating dropped-write counter.
module psg_write_bridge #(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cpu_wr,
  input  logic [7:0]               cpu_data,
  output logic                     cpu_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     nWE,
  output logic                     nCE,
  output logic [7:0]               D,
  input  logic                     READY
`ifdef PSG_BRIDGE_DROP_CNT_EN
  ,
  output logic [7:0]               drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAPS   = 2'd3
  } state_t;

  state_t state, next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    gcnt;
  logic          full, empty, push, pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign cpu_busy = full;
  assign push     = cpu_wr & ~full;
  assign pop      = (state == STROBE);

  // Storage only; never read while empty, so left unreset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= cpu_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  // Next-state logic; READY only matters while idle.
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (!empty && READY) next = SETUP;
      SETUP:   next = STROBE;
      STROBE:  next = GAPS;
      GAPS:    if (gcnt <= 4'd1) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Registered bus outputs and gap down-counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nWE  <= 1'b1;
      nCE  <= 1'b1;
      D    <= 8'h00;
      gcnt <= 4'd0;
    end else begin
      nWE <= (next != STROBE);
      nCE <= (next != STROBE);
      if (state == IDLE && next == SETUP) D <= mem[rd_ptr];
      if (state == STROBE)     gcnt <= 4'(GAP);
      else if (state == GAPS)  gcnt <= gcnt - 4'd1;
    end
  end

`ifdef PSG_BRIDGE_DROP_CNT_EN
  // Count writes refused because the FIFO was full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) drop_count <= 8'h00;
    else if (cpu_wr && full && drop_count != 8'hFF)
      drop_count <= drop_count + 8'h01;
  end
`endif

endmodule
